// File: rtl/instr_result_checker.sv
// Read-back checker for the instruction register: scans an inclusive, wrapping address range,
// recomputes each entry's result and reports mismatches plus checked/error totals.

package instr_register_pkg;
  typedef logic signed [31:0] operand_t;
  typedef logic signed [63:0] operand_res;
  typedef enum logic [3:0] {
    ZERO  = 4'd0,
    PASSA = 4'd1,
    PASSB = 4'd2,
    ADD   = 4'd3,
    SUB   = 4'd4,
    MULT  = 4'd5,
    DIV   = 4'd6,
    MOD   = 4'd7
  } opcode_t;
  typedef logic [4:0] address_t;
  typedef struct packed {
    opcode_t    opc;
    operand_t   op_a;
    operand_t   op_b;
    operand_res rezultat;
  } instruction_t;
endpackage

module instr_result_checker
  import instr_register_pkg::*;
(
  input  logic         clk,
  input  logic         reset_n,
  input  logic         start,
  input  address_t     first_ptr,
  input  address_t     last_ptr,
  input  instruction_t instruction_word,
  output address_t     read_pointer,
  output logic         busy,
  output logic         done,
  output logic         err_valid,
  output address_t     err_ptr,
  output operand_res   err_expected,
  output operand_res   err_actual,
  output logic [5:0]   checked_count,
  output logic [5:0]   error_count
);

  typedef enum logic [1:0] {StIdle, StFetch, StCheck, StDone} state_t;

  state_t       state_q;
  address_t     ptr_q;
  address_t     end_ptr_q;
  instruction_t iw_q;

  logic signed [63:0] a64, b64, expected;

  // Operands widened first so ADD/SUB/MULT are exact in 64 bits.
  always_comb begin
    a64      = {{32{iw_q.op_a[31]}}, iw_q.op_a};
    b64      = {{32{iw_q.op_b[31]}}, iw_q.op_b};
    expected = '0;
    case (iw_q.opc)
      ZERO:    expected = '0;
      PASSA:   expected = a64;
      PASSB:   expected = b64;
      ADD:     expected = a64 + b64;
      SUB:     expected = a64 - b64;
      MULT:    expected = a64 * b64;
      DIV:     expected = (b64 == 64'sd0) ? 64'sd0 : a64 / b64;
      MOD:     expected = (b64 == 64'sd0) ? 64'sd0 : a64 % b64;
      default: expected = '0;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= StIdle;
      ptr_q         <= '0;
      end_ptr_q     <= '0;
      iw_q          <= '0;
      read_pointer  <= '0;
      busy          <= 1'b0;
      done          <= 1'b0;
      err_valid     <= 1'b0;
      err_ptr       <= '0;
      err_expected  <= '0;
      err_actual    <= '0;
      checked_count <= '0;
      error_count   <= '0;
    end else begin
      done      <= 1'b0;
      err_valid <= 1'b0;
      case (state_q)
        StIdle: begin
          if (start) begin
            ptr_q         <= first_ptr;
            end_ptr_q     <= last_ptr;
            read_pointer  <= first_ptr;
            checked_count <= '0;
            error_count   <= '0;
            busy          <= 1'b1;
            state_q       <= StFetch;
          end
        end
        StFetch: begin
          iw_q    <= instruction_word;
          state_q <= StCheck;
        end
        StCheck: begin
          checked_count <= checked_count + 6'd1;
          if (expected != iw_q.rezultat) begin
            err_valid    <= 1'b1;
            err_ptr      <= ptr_q;
            err_expected <= expected;
            err_actual   <= iw_q.rezultat;
            if (error_count != 6'd63) error_count <= error_count + 6'd1;
          end
          if (ptr_q == end_ptr_q) begin
            done    <= 1'b1;
            state_q <= StDone;
          end else begin
            ptr_q        <= ptr_q + 5'd1;
            read_pointer <= ptr_q + 5'd1;
            state_q      <= StFetch;
          end
        end
        StDone: begin
          busy    <= 1'b0;
          state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule
